frame_buffer_port_a_arbiter: RTL and testbench
==============================================

Name: frame_buffer_port_a_arbiter

Overview:
- Owns port A (read/write) of the 256x128 1-bit frame buffer. Port B stays with the VGA signal generator.
- Shares port A between two requesters:
  - the microprocessor, through a req/ack bus with read-data return;
  - an internal fill engine that clears or sets all 32768 pixels on command.
- Sits between the microprocessor bus interface and the frame buffer's A_* ports, in the A_CLK domain.

Parameters:
- ADDR_WIDTH, 15, pixel address width (low 8 bits = X, high 7 bits = Y).
- LAST_ADDR, 2**ADDR_WIDTH-1, final address written by a fill.

Ports:
- CLK  in  1  system clock; drives the frame buffer's A_CLK.
- RESET  in  1  reset, synchronous and active-low.
- CPU_REQ  in  1  microprocessor access request; held until CPU_ACK.
- CPU_WE  in  1  1 = write, 0 = read; valid with CPU_REQ.
- CPU_ADDR  in  ADDR_WIDTH  pixel address; valid with CPU_REQ.
- CPU_DATA_IN  in  1  write pixel value.
- CPU_ACK  out  1  one-cycle pulse: request issued to memory.
- CPU_RD_VALID  out  1  one-cycle pulse: CPU_RD_DATA valid.
- CPU_RD_DATA  out  1  read pixel value.
- FILL_START  in  1  pulse: start a full-frame fill.
- FILL_VALUE  in  1  pixel value for the fill; sampled on start.
- FILL_BUSY  out  1  fill in progress.
- FILL_DONE  out  1  one-cycle pulse after the last fill write.
- FB_ADDR  out  ADDR_WIDTH  to frame buffer A_ADDR.
- FB_WDATA  out  1  to frame buffer A_DATA_IN.
- FB_WE  out  1  to frame buffer A_WE.
- FB_RDATA  in  1  from frame buffer A_DATA_OUT (registered in the memory, 1-cycle latency).

Behaviour:
- Reset: RESET=0 at a CLK edge clears all outputs and internal registers to 0, state IDLE. A fill in progress is aborted: no FILL_DONE, counter to 0. A pending read pipeline is flushed: no CPU_RD_VALID.
- All outputs are registered.
- FSM states:
  - IDLE: FILL_START=1 captures FILL_VALUE, counter<=0, FILL_BUSY<=1, go to FILL.
  - FILL: stays until the write to LAST_ADDR has issued, then FILL_DONE<=1 for one cycle, FILL_BUSY<=0, go to IDLE.
  - FILL_START while in FILL is ignored.
- Slot arbitration, evaluated every edge; CPU has fixed priority:
  - CPU grant condition: CPU_REQ=1 and CPU_ACK=0. The cycle in which ACK is high is a blackout, so the same request is not accepted twice. CPU throughput is at most one access per 2 cycles.
  - On a CPU grant at edge k:
    - FB_ADDR<=CPU_ADDR, FB_WE<=CPU_WE, FB_WDATA<=CPU_DATA_IN, CPU_ACK<=1.
    - If it is a read, rd_pend<=1.
  - Else, if in FILL: FB_ADDR<=counter, FB_WE<=1, FB_WDATA<=fill value, counter<=counter+1.
  - Else: FB_WE<=0; FB_ADDR holds its value.
- Read latency:
  - Grant at edge k; memory samples at edge k+1.
  - FB_RDATA is captured into CPU_RD_DATA at edge k+2, with CPU_RD_VALID high for the cycle after k+2.
  - Reads are pipelined. Back-to-back reads, one every 2 cycles, each return exactly once and in order.
- The fill is never starved: it writes in every non-CPU slot, i.e. at least every other cycle. Its minimum duration is 32768 cycles.
- Read-during-write: port A is read-first, so a CPU read issued in the cycle after a write to the same address sees the new data. Ordering is issue order.
- The counter saturates logic: after LAST_ADDR issues, no further fill writes occur (no wrap to 0).
- FILL_START coinciding with the final fill write (still in FILL) is ignored.
- A CPU write does not produce CPU_RD_VALID.

Decomposition:
- Package fb_pkg holds:
  - FB_ADDR_W=15, FB_X_W=8, FB_Y_W=7, FB_LAST_ADDR;
  - the state encoding {IDLE, FILL}.
- No sub-module is needed. The fill counter and the 2-stage read-valid shift register stay inline.

Test Plan:
- Reset, then a CPU write of 1 to addr 0x1234 followed by a read of 0x1234: FB_WE=1 for one cycle with FB_ADDR=0x1234; the read returns CPU_RD_DATA=1 with CPU_RD_VALID 2 cycles after the read's grant edge.
- FILL_START with FILL_VALUE=0 and no CPU traffic: FB_WE high for 32768 consecutive cycles over addresses 0..0x7FFF, then a FILL_DONE pulse, FILL_BUSY falls, FB_WE=0.
- Fill with continuous CPU_REQ reads of 0x0005 throughout: the CPU wins alternate slots, every fill address is still written exactly once, and FILL_DONE arrives after 65536±2 cycles. The read issued after fill address 5 is written returns FILL_VALUE.
- CPU_REQ held high for 3 back-to-back reads (0x10, 0x11, 0x12): CPU_ACK pulses 2 cycles apart, and three CPU_RD_VALID pulses arrive in order with the correct data.
- RESET=0 asserted mid-fill at counter 0x0100: FILL_BUSY=0, no FILL_DONE, FB_WE=0 next cycle. A new FILL_START after release restarts the fill at address 0.
- FILL_START pulsed again while FILL_BUSY=1 with a different FILL_VALUE: ignored, and the fill value and counter are unchanged.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared geometry and FSM encoding for the frame buffer port A arbiter.
package fb_pkg;
    localparam int FB_X_W       = 8;
    localparam int FB_Y_W       = 7;
    localparam int FB_ADDR_W    = 15;
    localparam int FB_LAST_ADDR = 2**FB_ADDR_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fb_state_t;
endpackage

// File: rtl/frame_buffer_port_a_arbiter.sv
// Shares frame buffer port A between the CPU (fixed priority) and a full-frame fill engine.
// Grant-to-memory 1 cycle, read data 2 cycles after grant; CPU blacked out the cycle ACK is high.
module frame_buffer_port_a_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH = FB_ADDR_W,
    parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
    input  logic                  CPU_DATA_IN,
    output logic                  CPU_ACK,
    output logic                  CPU_RD_VALID,
    output logic                  CPU_RD_DATA,
    input  logic                  FILL_START,
    input  logic                  FILL_VALUE,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic [ADDR_WIDTH-1:0] FB_ADDR,
    output logic                  FB_WDATA,
    output logic                  FB_WE,
    input  logic                  FB_RDATA
);

    localparam logic [ADDR_WIDTH-1:0] LAST = LAST_ADDR[ADDR_WIDTH-1:0];

    fb_state_t             state;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  fill_val;
    logic                  fill_end;
    logic                  rd_pend;
    logic                  rd_pend2;
    logic                  cpu_grant;
    logic                  fill_slot;

    // ACK high means this request was just taken; ignore it for one cycle.
    assign cpu_grant = CPU_REQ && !CPU_ACK;
    assign fill_slot = (state == FILL) && !fill_end;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            fill_val     <= 1'b0;
            fill_end     <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend2     <= 1'b0;
            CPU_ACK      <= 1'b0;
            CPU_RD_VALID <= 1'b0;
            CPU_RD_DATA  <= 1'b0;
            FILL_BUSY    <= 1'b0;
            FILL_DONE    <= 1'b0;
            FB_ADDR      <= '0;
            FB_WDATA     <= 1'b0;
            FB_WE        <= 1'b0;
        end else begin
            FILL_DONE    <= 1'b0;
            CPU_ACK      <= cpu_grant;
            rd_pend      <= cpu_grant && !CPU_WE;
            rd_pend2     <= rd_pend;
            CPU_RD_VALID <= rd_pend2;
            if (rd_pend2) begin
                CPU_RD_DATA <= FB_RDATA;
            end

            if (cpu_grant) begin
                FB_ADDR  <= CPU_ADDR;
                FB_WE    <= CPU_WE;
                FB_WDATA <= CPU_DATA_IN;
            end else if (fill_slot) begin
                FB_ADDR  <= fill_cnt;
                FB_WE    <= 1'b1;
                FB_WDATA <= fill_val;
            end else begin
                FB_WE    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (FILL_START) begin
                        fill_val  <= FILL_VALUE;
                        fill_cnt  <= '0;
                        fill_end  <= 1'b0;
                        FILL_BUSY <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // Counter parks on the last address; fill_end stops further writes.
                    if (fill_end) begin
                        FILL_DONE <= 1'b1;
                        FILL_BUSY <= 1'b0;
                        fill_end  <= 1'b0;
                        state     <= IDLE;
                    end else if (!cpu_grant) begin
                        if (fill_cnt == LAST) begin
                            fill_end <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_port_a_arbiter.sv
// Bench for frame_buffer_port_a_arbiter with a read-first frame buffer model and a pixel reference array.
module tb_frame_buffer_port_a_arbiter;
    localparam int AW   = 14;
    localparam int NPIX = 2**AW;
    localparam int LAST = NPIX - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_din;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack, cpu_rd_valid, cpu_rd_data;
    logic          fill_start, fill_value, fill_busy, fill_done;
    logic [AW-1:0] fb_addr;
    logic          fb_wdata, fb_we;
    logic          fb_rdata = 1'b0;

    logic          fb_mem [0:NPIX-1] = '{default: 1'b0};
    logic          ref_mem [0:NPIX-1];
    byte unsigned  wcnt [0:NPIX-1];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    frame_buffer_port_a_arbiter #(.ADDR_WIDTH(AW)) dut (
        .CLK(clk), .RESET(reset),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_DATA_IN(cpu_din),
        .CPU_ACK(cpu_ack), .CPU_RD_VALID(cpu_rd_valid), .CPU_RD_DATA(cpu_rd_data),
        .FILL_START(fill_start), .FILL_VALUE(fill_value),
        .FILL_BUSY(fill_busy), .FILL_DONE(fill_done),
        .FB_ADDR(fb_addr), .FB_WDATA(fb_wdata), .FB_WE(fb_we), .FB_RDATA(fb_rdata)
    );

    // Frame buffer port A: registered read, read-first on a same-address write.
    always @(posedge clk) begin
        fb_rdata <= fb_mem[fb_addr];
        if (fb_we) fb_mem[fb_addr] <= fb_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic d,
                              output int lat, output logic [AW-1:0] f_addr, output logic f_we,
                              output logic f_wd, output logic f_we1, output logic [2:0] rv,
                              output logic rd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = d; lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 16);
        f_addr = fb_addr; f_we = fb_we; f_wd = fb_wdata;
        cpu_req = 1'b0;
        tick(); f_we1 = fb_we; rv[0] = cpu_rd_valid;
        tick(); rv[1] = cpu_rd_valid; rd = cpu_rd_data;
        tick(); rv[2] = cpu_rd_valid;
    endtask

    task automatic test_reset();
        logic [AW+6:0] outs;
        reset = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = 0;
        fill_start = 0; fill_value = 0;
        repeat (3) tick();
        outs = {cpu_ack, cpu_rd_valid, cpu_rd_data, fill_busy, fill_done, fb_wdata, fb_we, fb_addr};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        reset = 1'b1;
        tick();
        outs = {cpu_ack, cpu_rd_valid, cpu_rd_data, fill_busy, fill_done, fb_wdata, fb_we, fb_addr};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL idle_after_reset: got %h want 0", outs); end
    endtask

    task automatic test_write_read();
        int lat; logic [AW-1:0] fa; logic fw, fd, fw1, rd, val; logic [2:0] rv;
        logic [AW+9:0] obs, expv;
        for (int p = 0; p < 2; p++) begin
            val = (p == 0);
            cpu_access(1'b1, AW'('h1234), val, lat, fa, fw, fd, fw1, rv, rd);
            ref_mem['h1234] = val;
            obs  = {lat[4:0], fa, fw, fd, fw1, rv};
            expv = {5'd1, AW'('h1234), 1'b1, val, 1'b0, 3'b000};
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL write_1234: got %h want %h", obs, expv); end
            cpu_access(1'b0, AW'('h1234), 1'b0, lat, fa, fw, fd, fw1, rv, rd);
            obs  = {lat[4:0], fa, fw, fw1, rv, rd};
            expv = {5'd1, AW'('h1234), 1'b0, 1'b0, 3'b010, val};
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL read_1234: got %h want %h", obs, expv); end
        end
    endtask

    task automatic test_random_cpu();
        int lat; logic [AW-1:0] fa, a, prev_a; logic fw, fd, fw1, rd, we, d; logic [2:0] rv;
        logic [AW+9:0] obs, expv;
        prev_a = AW'('h1234);
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            d  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 1) ? prev_a : AW'($urandom_range(0, NPIX - 1));
            cpu_access(we, a, d, lat, fa, fw, fd, fw1, rv, rd);
            if (we) begin
                obs  = {lat[4:0], fa, fw, fd, rv, 1'b0};
                expv = {5'd1, a, 1'b1, d, 3'b000, 1'b0};
                ref_mem[a] = d;
            end else begin
                obs  = {lat[4:0], fa, fw, rv, rd};
                expv = {5'd1, a, 1'b0, 3'b010, ref_mem[a]};
            end
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random_cpu[%0d] we=%0b: got %h want %h", i, we, obs, expv);
            end
            prev_a = a;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] oa [5]; logic ow [5]; logic od [5];
        int ack_cyc [5]; int nack; int lat;
        int exp_cyc [$]; logic exp_dat [$]; int rv_cyc [$]; logic rv_dat [$];
        logic [AW-1:0] fa; logic fw, fd, fw1, rd; logic [2:0] rv;
        for (int i = 0; i < 3; i++)
            begin
                od[0] = 1'($urandom_range(0, 1));
                cpu_access(1'b1, AW'('h10 + i), od[0], lat, fa, fw, fd, fw1, rv, rd);
                ref_mem['h10 + i] = od[0];
            end
        oa[0] = AW'($urandom_range(0, NPIX - 1)); oa[1] = oa[0];
        oa[2] = AW'('h10); oa[3] = AW'('h11); oa[4] = AW'('h12);
        ow[0] = 1'b1; ow[1] = 1'b0; ow[2] = 1'b0; ow[3] = 1'b0; ow[4] = 1'b0;
        od[0] = ~ref_mem[oa[0]];
        for (int i = 1; i < 5; i++) od[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ow[i]) ref_mem[oa[i]] = od[i];
            else begin exp_cyc.push_back(2 * i + 3); exp_dat.push_back(ref_mem[oa[i]]); end
        end
        nack = 0;
        cpu_req = 1'b1; cpu_we = ow[0]; cpu_addr = oa[0]; cpu_din = od[0];
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (cpu_ack) begin
                if (nack < 5) ack_cyc[nack] = c;
                nack++;
                if (nack < 5) begin cpu_we = ow[nack]; cpu_addr = oa[nack]; cpu_din = od[nack]; end
                else cpu_req = 1'b0;
            end
            if (cpu_rd_valid) begin rv_cyc.push_back(c); rv_dat.push_back(cpu_rd_data); end
        end
        cpu_req = 1'b0;
        n_checks++;
        if (nack != 5) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 5", nack); end
        for (int i = 0; i < 5 && i < nack; i++) begin
            n_checks++;
            if (ack_cyc[i] != 2 * i + 1) begin
                n_fail++; $display("FAIL b2b_ack_cycle[%0d]: got %0d want %0d", i, ack_cyc[i], 2 * i + 1);
            end
        end
        n_checks++;
        if (rv_cyc.size() != exp_cyc.size()) begin
            n_fail++; $display("FAIL b2b_rd_count: got %0d want %0d", rv_cyc.size(), exp_cyc.size());
        end
        for (int j = 0; j < rv_cyc.size() && j < exp_cyc.size(); j++) begin
            n_checks++;
            if (rv_cyc[j] != exp_cyc[j] || rv_dat[j] !== exp_dat[j]) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got cyc %0d data %0b want cyc %0d data %0b",
                         j, rv_cyc[j], rv_dat[j], exp_cyc[j], exp_dat[j]);
            end
        end
    endtask

    task automatic test_fill_plain();
        logic v; int bad, first_bad, mem_bad; logic [2:0] obs;
        v = 1'($urandom_range(0, 1));
        fill_value = v; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        obs = {fill_busy, fill_done, fb_we};
        n_checks++;
        if (obs !== 3'b100) begin n_fail++; $display("FAIL fill_start_state: got %b want 100", obs); end
        bad = 0; first_bad = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 100) begin fill_start = 1'b1; fill_value = ~v; end
            else fill_start = (i == LAST);
            tick();
            if (!(fb_we === 1'b1 && fb_addr === AW'(i) && fb_wdata === v &&
                  fill_busy === 1'b1 && fill_done === 1'b0)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        fill_start = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL fill_sequence: %0d bad cycles (first at slot %0d) want 0", bad, first_bad);
        end
        tick();
        obs = {fill_busy, fill_done, fb_we};
        n_checks++;
        if (obs !== 3'b010) begin n_fail++; $display("FAIL fill_done_pulse: got %b want 010", obs); end
        tick();
        obs = {fill_busy, fill_done, fb_we};
        n_checks++;
        if (obs !== 3'b000) begin n_fail++; $display("FAIL fill_after_done: got %b want 000", obs); end
        mem_bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (fb_mem[i] !== v) mem_bad++;
            ref_mem[i] = v;
        end
        n_checks++;
        if (mem_bad != 0) begin n_fail++; $display("FAIL fill_contents: %0d wrong pixels want 0", mem_bad); end
    endtask

    task automatic test_fill_contended();
        logic v2, old5, written5, e, last_rd; int cyc, done_cyc, nack, nrv, rdbad, wbad, cnt_bad;
        logic exp_q [$];
        v2 = ~ref_mem[5]; old5 = ref_mem[5]; written5 = 1'b0; last_rd = old5;
        for (int i = 0; i < NPIX; i++) wcnt[i] = 0;
        cyc = 0; done_cyc = -1; nack = 0; nrv = 0; rdbad = 0; wbad = 0;
        fill_value = v2; fill_start = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
        while (cyc < 2 * NPIX + 50) begin
            if (done_cyc >= 0) cpu_req = 1'b0;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            tick(); cyc++;
            fill_start = 1'b0;
            if (fb_we) begin
                if (fb_wdata !== v2) wbad++;
                if (wcnt[fb_addr] < 200) wcnt[fb_addr] = wcnt[fb_addr] + 1;
                if (fb_addr == AW'(5)) written5 = 1'b1;
            end
            if (cpu_ack) begin nack++; exp_q.push_back(written5 ? v2 : old5); end
            if (cpu_rd_valid) begin
                nrv++;
                last_rd = cpu_rd_data;
                if (exp_q.size() == 0) rdbad++;
                else begin e = exp_q.pop_front(); if (cpu_rd_data !== e) rdbad++; end
            end
            if (fill_done && done_cyc < 0) done_cyc = cyc;
        end
        cpu_req = 1'b0;
        n_checks++;
        if (done_cyc < 0) begin n_fail++; $display("FAIL contended_done_timeout: no FILL_DONE in %0d cycles", cyc); end
        n_checks++;
        if (done_cyc - 1 < 2 * NPIX - 2 || done_cyc - 1 > 2 * NPIX + 2) begin
            n_fail++; $display("FAIL contended_duration: got %0d want %0d+-2", done_cyc - 1, 2 * NPIX);
        end
        cnt_bad = 0;
        for (int i = 0; i < NPIX; i++) if (wcnt[i] != 1) cnt_bad++;
        n_checks++;
        if (cnt_bad != 0 || wbad != 0) begin
            n_fail++; $display("FAIL contended_writes: %0d addrs not written once, %0d bad values, want 0 0", cnt_bad, wbad);
        end
        n_checks++;
        if (nack < NPIX - 1 || nack > NPIX + 3) begin
            n_fail++; $display("FAIL contended_cpu_share: got %0d acks want about %0d", nack, NPIX);
        end
        n_checks++;
        if (nrv != nack || exp_q.size() != 0) begin
            n_fail++; $display("FAIL contended_read_count: got %0d valids for %0d acks", nrv, nack);
        end
        n_checks++;
        if (rdbad != 0) begin n_fail++; $display("FAIL contended_read_data: %0d wrong reads want 0", rdbad); end
        n_checks++;
        if (last_rd !== v2) begin n_fail++; $display("FAIL contended_last_read: got %0b want %0b", last_rd, v2); end
        for (int i = 0; i < NPIX; i++) ref_mem[i] = v2;
    endtask

    task automatic test_reset_mid_fill();
        int n; logic ack_seen, rv_seen, done_seen, busy_seen, we_seen;
        logic [AW+1:0] pre, pre_exp; logic [AW+6:0] outs; logic [AW+1:0] st;
        fill_value = 1'b1; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        n = 0;
        while (!(fb_we === 1'b1 && fb_addr === AW'('hFF)) && n < 1000) begin tick(); n++; end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
        tick();
        ack_seen = cpu_ack; cpu_req = 1'b0;
        tick();
        pre = {ack_seen, fb_we, fb_addr}; pre_exp = {1'b1, 1'b1, AW'('h100)};
        n_checks++;
        if (pre !== pre_exp) begin n_fail++; $display("FAIL pre_reset_state: got %h want %h", pre, pre_exp); end
        reset = 1'b0;
        tick();
        outs = {cpu_ack, cpu_rd_valid, cpu_rd_data, fill_busy, fill_done, fb_wdata, fb_we, fb_addr};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL mid_fill_reset: got %h want 0", outs); end
        reset = 1'b1;
        rv_seen = 0; done_seen = 0; busy_seen = 0; we_seen = 0;
        repeat (6) begin
            tick();
            rv_seen |= cpu_rd_valid; done_seen |= fill_done; busy_seen |= fill_busy; we_seen |= fb_we;
        end
        n_checks++;
        if ({rv_seen, done_seen, busy_seen, we_seen} !== 4'b0000) begin
            n_fail++; $display("FAIL after_abort: got rv/done/busy/we %b want 0000",
                               {rv_seen, done_seen, busy_seen, we_seen});
        end
        fill_value = 1'b0; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            st = {fill_busy, fb_we, fb_addr};
            n_checks++;
            if (st !== {1'b1, 1'b1, AW'(i)}) begin
                n_fail++; $display("FAIL restart_addr[%0d]: got %h want %h", i, st, {1'b1, 1'b1, AW'(i)});
            end
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) ref_mem[i] = 1'b0;
        test_reset();
        test_write_read();
        test_random_cpu();
        test_back_to_back();
        test_fill_plain();
        test_fill_contended();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
